// File: rtl/stim_sequencer.sv
// Pattern sequencer for a WIDTH-input combinational circuit-under-test: apply, settle, sample f, count ones.
// Optional MISR signature over the sampled f values is built only when SIGNATURE_EN is defined.
module stim_sequencer #(
    parameter int WIDTH  = 30,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_patterns,
    output logic [WIDTH-1:0] pat_out,
    input  logic             f_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ones_count,
    output logic [15:0]      signature
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int WAIT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [WAIT_W-1:0] SETTLE_LD = WAIT_W'(SETTLE);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SIGNATURE_EN
    logic [15:0]        sig_q, sig_d;
`endif

    // Counter mode increments; LFSR mode shifts left with taps for x^30+x^6+x^4+x+1.
    function automatic logic [WIDTH-1:0] next_pattern(input logic [WIDTH-1:0] p, input logic lfsr);
        logic fb;
        fb = p[WIDTH-1] ^ p[5] ^ p[3] ^ p[0];
        if (lfsr) begin
            next_pattern = {p[WIDTH-2:0], fb};
        end else begin
            next_pattern = p + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

`ifdef SIGNATURE_EN
    // One MISR step (CRC-16/CCITT polynomial) folding in a single sampled bit.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
        misr_step = ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {15'b0, b};
    endfunction
`endif

    // Next-state and datapath logic for the sweep FSM.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        num_d   = num_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        pat_d   = pat_q;
        ones_d  = ones_q;
`ifdef SIGNATURE_EN
        sig_d   = sig_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    num_d  = num_patterns;
                    idx_d  = {CNT_W{1'b0}};
                    ones_d = {CNT_W{1'b0}};
`ifdef SIGNATURE_EN
                    sig_d  = 16'h0000;
`endif
                    if (num_patterns == {CNT_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        // An all-zero LFSR state never leaves zero, so substitute 1.
                        if (mode && (seed == {WIDTH{1'b0}})) begin
                            pat_d = {{(WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            pat_d = seed;
                        end
                        state_d = S_APPLY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_APPLY: begin
                wait_d = SETTLE_LD;
                if (SETTLE == 32'sd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                wait_d = wait_q - {{(WAIT_W-1){1'b0}}, 1'b1};
                if (wait_q <= {{(WAIT_W-1){1'b0}}, 1'b1}) begin
                    state_d = S_SAMPLE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SAMPLE: begin
                ones_d = ones_q + {{(CNT_W-1){1'b0}}, f_in};
`ifdef SIGNATURE_EN
                sig_d  = misr_step(sig_q, f_in);
`endif
                idx_d  = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (idx_q == (num_q - {{(CNT_W-1){1'b0}}, 1'b1})) begin
                    state_d = S_DONE;
                end else begin
                    pat_d   = next_pattern(pat_q, mode_q);
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
    end

    // State register with synchronous reset; a reset mid-sweep aborts without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            num_q   <= {CNT_W{1'b0}};
            idx_q   <= {CNT_W{1'b0}};
            wait_q  <= {WAIT_W{1'b0}};
            pat_q   <= {WIDTH{1'b0}};
            ones_q  <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SIGNATURE_EN
            sig_q   <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            pat_q   <= pat_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SIGNATURE_EN
            sig_q   <= sig_d;
`endif
        end
    end

    assign pat_out    = pat_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_count = ones_q;
`ifdef SIGNATURE_EN
    assign signature  = sig_q;
`else
    assign signature  = 16'h0000;
`endif

endmodule
